// File: rtl/pe_relay_fifo.sv
// pe_relay_fifo: rewrites the leaf and data fields of valid network packets, buffers
// them in a FIFO and relays them through a retry-capable output register.
// Define PE_RELAY_STATS_EN to build the rx/tx/drop statistics counters.
module pe_relay_fifo #(
    parameter int NUM_LEAVES  = 256,
    parameter int P_SZ        = 32,
    parameter int DATA_W      = 15,
    parameter int FIFO_DEPTH  = 4,
    parameter int LEAF_STRIDE = 1,
    parameter int DATA_INC    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [P_SZ-1:0]             interface_pe,
    input  logic                        resend,
    input  logic                        hold,
    output logic [P_SZ-1:0]             pe_interface,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 rx_count,
    output logic [15:0]                 tx_count,
    output logic [15:0]                 drop_count
);
    localparam int L  = $clog2(NUM_LEAVES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    generate
        if (P_SZ < 1 + 2 * L + DATA_W) begin : g_bad_psz
            $error("pe_relay_fifo: P_SZ too small for valid, leaf, sequence and data fields");
        end
        if ((FIFO_DEPTH < 2) || ((1 << AW) != FIFO_DEPTH)) begin : g_bad_depth
            $error("pe_relay_fifo: FIFO_DEPTH must be a power of two and at least 2");
        end
        if ((1 << L) != NUM_LEAVES) begin : g_bad_leaves
            $error("pe_relay_fifo: NUM_LEAVES must be a power of two");
        end
    endgenerate

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } stage_state_t;

    // Leaf and data wrap naturally at their field widths; every other bit passes through.
    function automatic logic [P_SZ-1:0] relay_xform(input logic [P_SZ-1:0] pkt);
        logic [P_SZ-1:0]   res;
        logic [L-1:0]      leaf;
        logic [DATA_W-1:0] data;
        res  = pkt;
        leaf = pkt[P_SZ-2 -: L] + L'(LEAF_STRIDE);
        data = pkt[DATA_W-1:0] + DATA_W'(DATA_INC);
        res[P_SZ-1]         = 1'b1;
        res[P_SZ-2 -: L]    = leaf;
        res[DATA_W-1:0]     = data;
        return res;
    endfunction

    // Reset release is synchronised so no capture happens on the first edge after it.
    logic [1:0] rst_sync;
    logic       run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    // Stage p0: input capture and transform
    logic            in_vld_p0;
    logic [P_SZ-1:0] xf_p0;

    assign in_vld_p0 = run & interface_pe[P_SZ-1];
    assign xf_p0     = relay_xform(interface_pe);

    logic [P_SZ-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_q;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
    // A full FIFO still accepts when the output stage drains the head this cycle.
    assign push       = in_vld_p0 && (!fifo_full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= xf_p0;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    assign fifo_level = level_q;

    // Stage p1: output register, EMPTY or BUSY with one packet
    stage_state_t    state_q;
    stage_state_t    state_d;
    logic [P_SZ-1:0] pkt_p1;
    logic [P_SZ-1:0] pkt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            pkt_p1  <= '0;
        end else begin
            state_q <= state_d;
            pkt_p1  <= pkt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_p1;
        pop     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    pkt_d   = fifo_mem[rd_ptr];
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!resend && !hold) begin
                    if (!fifo_empty) begin
                        pop   = 1'b1;
                        pkt_d = fifo_mem[rd_ptr];
                    end else begin
                        pkt_d   = '0;
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: begin
                pkt_d   = '0;
                state_d = ST_EMPTY;
            end
        endcase
    end

    assign pe_interface = pkt_p1;

`ifdef PE_RELAY_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    logic tx_acc;
    logic drop;

    assign tx_acc = (state_q == ST_BUSY) && !resend && !hold;
    assign drop   = in_vld_p0 && !push;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_count   <= '0;
            tx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (in_vld_p0) rx_count   <= sat_inc(rx_count);
            if (tx_acc)    tx_count   <= sat_inc(tx_count);
            if (drop)      drop_count <= sat_inc(drop_count);
        end
    end
`else
    assign rx_count   = '0;
    assign tx_count   = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_pe_relay_fifo.sv
// Randomised bench for pe_relay_fifo against a queue-based packet model, plus directed cases.
module tb_pe_relay_fifo;
    localparam int DEPTH = 4;
`ifdef PE_RELAY_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] interface_pe = 32'h0;
    logic        resend = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] pe_interface;
    logic [2:0]  fifo_level;
    logic [15:0] rx_count;
    logic [15:0] tx_count;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    pe_relay_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .interface_pe (interface_pe),
        .resend       (resend),
        .hold         (hold),
        .pe_interface (pe_interface),
        .fifo_level   (fifo_level),
        .rx_count     (rx_count),
        .tx_count     (tx_count),
        .drop_count   (drop_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit model_en = 1'b0;

    logic [31:0] m_q[$];
    bit          m_busy;
    logic [31:0] m_stage;
    int          m_rx, m_tx, m_drop;

    function automatic logic [31:0] pkt(input logic [7:0] lf, input logic [7:0] sq,
                                        input logic [14:0] d);
        return {1'b1, lf, sq, d};
    endfunction

    function automatic logic [31:0] xf(input logic [31:0] p);
        int leaf, data;
        leaf = (int'(p[30:23]) + 1) % 256;
        data = (int'(p[14:0]) + 1) % 32768;
        return {1'b1, 8'(leaf), p[22:15], 15'(data)};
    endfunction

    function automatic int sat(input int c);
        return (c >= 65535) ? 65535 : c + 1;
    endfunction

    // One clock edge of the packet-level model, using the inputs present at that edge.
    task automatic model_step();
        int n;
        bit pop_m;
        n = m_q.size();
        pop_m = 1'b0;
        if (!m_busy) begin
            pop_m = (n > 0);
        end else if (!resend && !hold) begin
            m_tx = sat(m_tx);
            if (n > 0) pop_m = 1'b1;
            else begin
                m_busy  = 1'b0;
                m_stage = 32'h0;
            end
        end
        if (interface_pe[31]) begin
            m_rx = sat(m_rx);
            if (n < DEPTH || pop_m) m_q.push_back(xf(interface_pe));
            else m_drop = sat(m_drop);
        end
        if (pop_m) begin
            m_stage = m_q.pop_front();
            m_busy  = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (!model_en) begin
            m_q.delete();
            m_busy  = 1'b0;
            m_stage = 32'h0;
            m_rx    = 0;
            m_tx    = 0;
            m_drop  = 0;
        end else begin
            model_step();
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        if (model_en) begin
            check("m_pe_interface", pe_interface, m_busy ? m_stage : 32'h0);
            check("m_fifo_level", 32'(fifo_level), 32'(m_q.size()));
            check("m_rx_count", 32'(rx_count), STATS ? 32'(m_rx) : 32'h0);
            check("m_tx_count", 32'(tx_count), STATS ? 32'(m_tx) : 32'h0);
            check("m_drop_count", 32'(drop_count), STATS ? 32'(m_drop) : 32'h0);
        end
    endtask

    // Called at a falling edge: drive inputs, pass one rising edge, compare at the next falling edge.
    task automatic step(input logic [31:0] p, input logic rs, input logic hd);
        interface_pe = p;
        resend       = rs;
        hold         = hd;
        @(negedge clk);
        compare_model();
    endtask

    task automatic release_reset();
        reset = 1'b1;
        step(pkt(8'h11, 8'h22, 15'h0033), 1'b0, 1'b0);
        check("sync_first_edge_level", 32'(fifo_level), 32'h0);
        check("sync_first_edge_rx", 32'(rx_count), 32'h0);
        repeat (4) step(32'h0, 1'b0, 1'b0);
        check("sync_idle_pe", pe_interface, 32'h0);
        model_en = 1'b1;
    endtask

    initial begin
        logic [31:0] p;
        @(negedge clk);
        repeat (2) @(negedge clk);
        check("reset_pe", pe_interface, 32'h0);
        check("reset_level", 32'(fifo_level), 32'h0);
        check("reset_rx", 32'(rx_count), 32'h0);
        release_reset();

        // single packet: {1,05,3C,0010} -> {1,06,3C,0011}
        step(32'h829E0010, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0);
        check("single_out", pe_interface, 32'h831E0011);
        step(32'h0, 1'b0, 1'b0);
        check("single_tx", 32'(tx_count), STATS ? 32'd1 : 32'd0);
        check("single_empty", pe_interface, 32'h0);

        // wrap of leaf and data
        step(32'hFF9E7FFF, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0);
        check("wrap_out", pe_interface, 32'h801E0000);
        step(32'h0, 1'b0, 1'b0);

        // resend held three cycles
        step(pkt(8'h10, 8'h01, 15'h0100), 1'b0, 1'b0);
        step(pkt(8'h20, 8'h02, 15'h0200), 1'b0, 1'b0);
        check("retry_first", pe_interface, 32'h88808101);
        for (int i = 0; i < 3; i++) begin
            step(32'h0, 1'b1, 1'b0);
            check("retry_stable", pe_interface, 32'h88808101);
        end
        step(32'h0, 1'b0, 1'b0);
        check("retry_next", pe_interface, 32'h90810201);
        step(32'h0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0);

        // overflow under hold: 7 back-to-back packets
        for (int i = 0; i < 7; i++) begin
            step(pkt(8'h30 + 8'(i), 8'h40 + 8'(i), 15'(i)), 1'b0, 1'b1);
        end
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_stage", pe_interface, 32'h98A00001);
        check("ovf_drop", 32'(drop_count), STATS ? 32'd2 : 32'd0);
        check("ovf_rx", 32'(rx_count), STATS ? 32'd11 : 32'd0);

        // full FIFO with simultaneous pop and push
        step(pkt(8'h50, 8'h60, 15'h0007), 1'b0, 1'b0);
        check("full_pp_level", 32'(fifo_level), 32'd4);
        check("full_pp_drop", 32'(drop_count), STATS ? 32'd2 : 32'd0);
        check("full_pp_stage", pe_interface, 32'h99208002);
        repeat (6) step(32'h0, 1'b0, 1'b0);
        check("drain_tx", 32'(tx_count), STATS ? 32'd10 : 32'd0);
        check("drain_level", 32'(fifo_level), 32'd0);

        // asynchronous reset with three packets buffered
        for (int i = 0; i < 4; i++) begin
            step(pkt(8'h70 + 8'(i), 8'h01, 15'(i)), 1'b0, 1'b1);
        end
        check("pre_reset_level", 32'(fifo_level), 32'd3);
        model_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_pe", pe_interface, 32'h0);
        check("async_reset_level", 32'(fifo_level), 32'h0);
        check("async_reset_rx", 32'(rx_count), 32'h0);
        check("async_reset_drop", 32'(drop_count), 32'h0);
        interface_pe = 32'h0;
        hold = 1'b0;
        @(negedge clk);
        repeat (2) step(32'h0, 1'b0, 1'b0);
        release_reset();

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            p = $urandom;
            p[31] = ($urandom_range(0, 9) < 6);
            step(p, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end
        repeat (12) step(32'h0, 1'b0, 1'b0);
        check("final_level", 32'(fifo_level), 32'h0);
        check("final_pe", pe_interface, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_relay_fifo.md
PE_RELAY_FIFO -- requirements
Module: pe_relay_fifo

Interface
REQ-001 Parameter NUM_LEAVES, 256, leaf count of the BFT; L = clog2(NUM_LEAVES).
REQ-002 Parameter P_SZ, 32, packet width: [P_SZ-1] valid, [P_SZ-2:P_SZ-1-L] leaf, next L bits sequence, [DATA_W-1:0] data.
REQ-003 Parameter DATA_W, 15, width of the data field; P_SZ >= 1+2L+DATA_W is enforced by an elaboration-time check.
REQ-004 Parameter FIFO_DEPTH, 4, buffered packets, power of two, >= 2.
REQ-005 Parameter LEAF_STRIDE, 1, added to the leaf field modulo NUM_LEAVES.
REQ-006 Parameter DATA_INC, 1, added to the data field modulo 2^DATA_W.
REQ-007 clk  input  1  single clock; every flop updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 interface_pe  input  P_SZ  packet from the network; captured when bit [P_SZ-1] = 1.
REQ-010 resend  input  1  network rejected the packet currently on pe_interface.
REQ-011 hold  input  1  freezes transmission when 1; reception continues.
REQ-012 pe_interface  output  P_SZ  registered packet to the network.
REQ-013 fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 rx_count, tx_count, drop_count  output  16 each  saturating statistics.

Function
REQ-015 A valid input is transformed: data += DATA_INC (wraps), leaf += LEAF_STRIDE (wraps), sequence and all other bits are unchanged, valid = 1.
REQ-016 The transformed packet is pushed into the FIFO at the edge where it is sampled, unless the push is rejected.
REQ-017 A push is rejected only when the FIFO is full and no pop occurs in the same cycle; a rejected packet is discarded and drop_count increments.
REQ-018 The output stage is either EMPTY (pe_interface = 0) or BUSY (holds one packet with valid = 1).
REQ-019 In BUSY, when resend = 0 and hold = 0 at an edge, the packet is accepted and tx_count increments; the stage reloads from the FIFO head if the FIFO is non-empty, otherwise it goes EMPTY.
REQ-020 In BUSY, when resend = 1 or hold = 1, pe_interface is unchanged (retry); resend has priority over hold for status.
REQ-021 In EMPTY with a non-empty FIFO, the stage loads the head at the next edge; a load and a push in the same cycle are both honoured.
REQ-022 Latency with an idle block: a packet sampled at edge k appears on pe_interface after edge k+1.
REQ-023 Ordering is strict FIFO; no packet is duplicated or reordered.
REQ-024 resend while EMPTY is ignored.
REQ-025 rx_count increments once per valid input, including dropped packets.
REQ-026 All counters saturate at 16'hFFFF.
REQ-027 fifo_level excludes the output stage and never exceeds FIFO_DEPTH.

Reset
REQ-028 With reset low, all flops clear asynchronously: pe_interface = 0, FIFO empty, fifo_level = 0, all counters = 0, output stage EMPTY.
REQ-029 Reset mid-transfer discards all buffered packets; reset deassertion is synchronised internally so the first capture occurs no earlier than the second edge after release.

Configuration
REQ-030 Macro PE_RELAY_STATS_EN: when defined, rx_count, tx_count and drop_count behave per REQ-017, REQ-019, REQ-025 and REQ-026.
REQ-031 When PE_RELAY_STATS_EN is undefined, the three counters are tied to 0 and no counter flops are synthesised; drop behaviour is unchanged.

Verification (defaults NUM_LEAVES=256, P_SZ=32, DATA_W=15, FIFO_DEPTH=4)
REQ-032 Single packet: valid, leaf 8'h05, seq 8'h3C, data 15'h0010 at edge 0 -> pe_interface = {1, 8'h06, 8'h3C, 15'h0011} after edge 1; tx_count = 1 after edge 2.
REQ-033 Wrap: leaf 8'hFF, data 15'h7FFF -> output leaf 8'h00, data 15'h0000, sequence unchanged.
REQ-034 Retry: resend held high for 3 cycles while BUSY -> pe_interface stable for those cycles, then the next packet appears; no loss.
REQ-035 Overflow: hold = 1 and 7 packets sent back-to-back -> output stage holds 1, FIFO holds 4, drop_count = 2, rx_count = 7; after hold = 0, 5 packets emerge in order.
REQ-036 Full plus simultaneous pop and push -> no drop, fifo_level stays 4.
REQ-037 Reset asserted with fifo_level = 3 -> immediately pe_interface = 0, fifo_level = 0, counters = 0, without waiting for a clock edge.
